// File: rtl/rns2bin_32_31_21_5_pkg.sv
`default_nettype none
// ============================================================================
// Package : rns_32_31_21_5_pkg
// Brief   : Moduli, MRC inverses, digit weights and FSM encoding for the
//           {32, 31, 21, 5} reverse converter.
// Rev     : 1.0
// ============================================================================
package rns_32_31_21_5_pkg;

  localparam int DYN_SIZE = 17;
  localparam int MAX_MOD  = 5;

  localparam int MOD_1 = 32;
  localparam int MOD_2 = 31;
  localparam int MOD_3 = 21;
  localparam int MOD_4 = 5;

  localparam int INV_32_M31 = 1;
  localparam int INV_32_M21 = 2;
  localparam int INV_32_M5  = 3;
  localparam int INV_31_M21 = 19;
  localparam int INV_31_M5  = 1;
  localparam int INV_21_M5  = 1;

  localparam int W2 = 32;
  localparam int W3 = 992;
  localparam int W4 = 20832;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_D1   = 3'd1,
    ST_D2   = 3'd2,
    ST_D3   = 3'd3,
    ST_D4   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rns2bin_32_31_21_5_if.sv
`default_nettype none
// ============================================================================
// Interface : rns2bin_32_31_21_5_if
// Brief     : Residue-in / binary-out valid-ready bus of the reverse converter.
// Rev       : 1.0
// ============================================================================
interface rns2bin_32_31_21_5_if;
  import rns_32_31_21_5_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [MAX_MOD-1:0]  in_mod_1;
  logic [MAX_MOD-1:0]  in_mod_2;
  logic [MAX_MOD-1:0]  in_mod_3;
  logic [MAX_MOD-1:0]  in_mod_4;
  logic                out_valid;
  logic                out_ready;
  logic [DYN_SIZE-1:0] out_data;
  logic                out_err;

  modport master (
    output in_valid, in_mod_1, in_mod_2, in_mod_3, in_mod_4, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_mod_1, in_mod_2, in_mod_3, in_mod_4, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

endinterface
`default_nettype wire

// File: rtl/rns2bin_32_31_21_5_mrc_step.sv
`default_nettype none
// ============================================================================
// Module : rns_mrc_step
// Brief  : One mixed-radix step, r = ((t - a mod M) mod M) * INV mod M.
// Rev    : 1.0
// ============================================================================
module rns_mrc_step
  import rns_32_31_21_5_pkg::*;
#(
  parameter int M   = 31,
  parameter int INV = 1
) (
  input  logic [MAX_MOD-1:0] i_t,
  input  logic [MAX_MOD-1:0] i_a,
  output logic [MAX_MOD-1:0] o_r
);

  logic [11:0] w_a_red;
  logic [11:0] w_diff;
  logic [11:0] w_prod;

  // Adding M before subtracting keeps the difference non-negative even when
  // t itself is an out-of-range residue.
  assign w_a_red = {7'd0, i_a} % 12'(M);
  assign w_diff  = ({7'd0, i_t} + 12'(M) - w_a_red) % 12'(M);
  assign w_prod  = (w_diff * 12'(INV)) % 12'(M);
  assign o_r     = MAX_MOD'(w_prod);

endmodule
`default_nettype wire

// File: rtl/rns2bin_32_31_21_5.sv
`default_nettype none
// ============================================================================
// Module : rns2bin_32_31_21_5
// Brief  : Sequential MRC reverse converter, {32,31,21,5} residues to binary.
// Rev    : 1.0
// ============================================================================
module rns2bin_32_31_21_5
  import rns_32_31_21_5_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  rns2bin_32_31_21_5_if.slave   bus
);

  state_t              r_state;
  state_t              w_state_next;
  logic [MAX_MOD-1:0]  r_t1, r_t2, r_t3, r_t4;
  logic [DYN_SIZE-1:0] r_acc;
  logic                r_err;
  logic [DYN_SIZE-1:0] r_out_data;
  logic                r_out_err;

  logic                w_accept;
  logic                w_err_in;
  logic [MAX_MOD-1:0]  w_d1_t2, w_d1_t3, w_d1_t4;
  logic [MAX_MOD-1:0]  w_d2_t3, w_d2_t4;
  logic [MAX_MOD-1:0]  w_d3_t4;
  logic [DYN_SIZE-1:0] w_acc_final;

  rns_mrc_step #(.M(MOD_2), .INV(INV_32_M31)) u_d1_m2 (.i_t(r_t2), .i_a(r_t1), .o_r(w_d1_t2));
  rns_mrc_step #(.M(MOD_3), .INV(INV_32_M21)) u_d1_m3 (.i_t(r_t3), .i_a(r_t1), .o_r(w_d1_t3));
  rns_mrc_step #(.M(MOD_4), .INV(INV_32_M5))  u_d1_m4 (.i_t(r_t4), .i_a(r_t1), .o_r(w_d1_t4));
  rns_mrc_step #(.M(MOD_3), .INV(INV_31_M21)) u_d2_m3 (.i_t(r_t3), .i_a(r_t2), .o_r(w_d2_t3));
  rns_mrc_step #(.M(MOD_4), .INV(INV_31_M5))  u_d2_m4 (.i_t(r_t4), .i_a(r_t2), .o_r(w_d2_t4));
  rns_mrc_step #(.M(MOD_4), .INV(INV_21_M5))  u_d3_m4 (.i_t(r_t4), .i_a(r_t3), .o_r(w_d3_t4));

  assign w_accept    = (r_state == ST_IDLE) && bus.in_valid;
  assign w_err_in    = (bus.in_mod_2 > 5'd30) | (bus.in_mod_3 > 5'd20) |
                       (bus.in_mod_4 > 5'd4)  | (|bus.in_mod_4[4:3]);
  assign w_acc_final = r_acc + DYN_SIZE'(r_t4) * DYN_SIZE'(W4);

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_data  = r_out_data;
  assign bus.out_err   = r_out_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid)  w_state_next = ST_D1;
      ST_D1:                      w_state_next = ST_D2;
      ST_D2:                      w_state_next = ST_D3;
      ST_D3:                      w_state_next = ST_D4;
      ST_D4:                      w_state_next = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_next = ST_IDLE;
      default:                    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_t1       <= '0;
      r_t2       <= '0;
      r_t3       <= '0;
      r_t4       <= '0;
      r_acc      <= '0;
      r_err      <= 1'b0;
      r_out_data <= '0;
      r_out_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_t1  <= bus.in_mod_1;
          r_t2  <= bus.in_mod_2;
          r_t3  <= bus.in_mod_3;
          r_t4  <= bus.in_mod_4;
          r_err <= w_err_in;
        end
        ST_D1: begin
          r_t2  <= w_d1_t2;
          r_t3  <= w_d1_t3;
          r_t4  <= w_d1_t4;
          r_acc <= DYN_SIZE'(r_t1);
        end
        ST_D2: begin
          r_t3  <= w_d2_t3;
          r_t4  <= w_d2_t4;
          r_acc <= r_acc + DYN_SIZE'(r_t2) * DYN_SIZE'(W2);
        end
        ST_D3: begin
          r_t4  <= w_d3_t4;
          r_acc <= r_acc + DYN_SIZE'(r_t3) * DYN_SIZE'(W3);
        end
        ST_D4: begin
          r_acc      <= w_acc_final;
          r_out_data <= r_err ? '0 : w_acc_final;
          r_out_err  <= r_err;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/rns2bin_32_31_21_5.md
# rns2bin_32_31_21_5

Reverse converter for the {32, 31, 21, 5} moduli set: accepts one residue 4-tuple and returns the binary integer X in [0, 104159] by sequential mixed-radix conversion (MRC), one digit per clock. Sits at the output end of the RNS datapath, as the counterpart of BIN2RNS_32_31_21_5; residue ports share that block's 5-bit lane format, so its outputs wire straight in for round-trip checks. Valid/ready handshakes on both sides.

## Interface
- DYN_SIZE, 17, output width; covers M = 104160.
- MAX_MOD, 5, width of every residue lane.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  residue tuple present.
- in_ready  out  1  block can accept; high only in IDLE.
- in_mod_1..in_mod_4  in  MAX_MOD each  residues mod 32, 31, 21, 5 (mod-5 lane uses low 3 bits, upper bits must be 0).
- out_valid  out  1  result present.
- out_ready  in  1  sink accepts result.
- out_data  out  DYN_SIZE  converted integer X.
- out_err  out  1  captured tuple had an out-of-range residue.

## Operation
- Digits: X = a1 + a2·32 + a3·992 + a4·20832, each ai < its modulus.
- Inverses (package constants): 32⁻¹ mod 31 = 1, mod 21 = 2, mod 5 = 3; 31⁻¹ mod 21 = 19, mod 5 = 1; 21⁻¹ mod 5 = 1.
- Step op: t ← ((t − (a mod m) + m) mod m) · inv mod m; a reduced mod m before subtracting.
- FSM: IDLE → D1 → D2 → D3 → D4 → DONE → IDLE.
- IDLE: on in_valid && in_ready, latch r1..r4 into t1..t4, latch err = (r2 > 30) | (r3 > 20) | (r4 > 4) | (in_mod_4[4:3] ≠ 0); → D1.
- D1: a1 = t1; update t2, t3, t4 with 32⁻¹; acc ← a1.
- D2: a2 = t2; update t3, t4 with 31⁻¹; acc ← acc + a2·32.
- D3: a3 = t3; update t4 with 21⁻¹; acc ← acc + a3·992.
- D4: acc ← acc + t4·20832; → DONE; out_data ← err ? 0 : acc; out_err ← err.
- DONE: out_valid = 1; out_data, out_err held stable until out_valid && out_ready, then → IDLE.
- in_valid ignored outside IDLE; no input buffering.

## Timing
- Reset (async, any state): state = IDLE, out_valid = 0, out_data = 0, out_err = 0, t1..t4 = 0, acc = 0; in_ready = 1 (decoded from IDLE). A conversion in flight is discarded, never output.
- Latency: accept edge E0; out_valid rises after edge E4 (4 cycles).
- out_valid && out_ready at edge Ek: out_valid low and in_ready high from Ek onward; next accept no earlier than Ek+1. Minimum 6 cycles per conversion.
- Backpressure: out_ready low holds DONE indefinitely; outputs unchanged.
- acc never exceeds 104159 for legal inputs; 17 bits, no wrap. Illegal inputs: intermediate values still computed mod m, result forced to 0.

## Structure
- Package rns_32_31_21_5_pkg: moduli, six inverse constants, weights 32/992/20832, DYN_SIZE, MAX_MOD, FSM state encoding.
- Sub-module rns_mrc_step (parameter M, INV): combinational (t, a) → ((t − a mod M) mod M)·INV mod M; instanced six times (three in D1, two in D2, one in D3), muxed by state.

## Test plan
- (0,0,0,0) → out_data 0, out_err 0, out_valid 4 cycles after accept.
- (31,30,20,4) → 104159; (31,1,15,0) → 65535; (3,6,15,4) → 99.
- Round trip N = 1..99 through BIN2RNS_32_31_21_5 → out_data = N every time, out_err 0.
- (0,31,0,0) and (0,0,21,0) → out_err 1, out_data 0.
- out_ready low 10 cycles in DONE → out_valid, out_data stable, in_ready 0; release → IDLE next edge, in_ready 1.
- reset pulsed low in D2 → out_valid 0, out_data 0, in_ready 1 immediately; next tuple (1,1,1,1) → 1.
